// File: rtl/sdfa_sram_ctrl_if.sv
// rtl/sdfa_sram_ctrl_if.sv - loader, requester, read-return and SRAM signals of the weight SRAM sequencer

interface sdfa_sram_ctrl_if #(
    parameter int ADDR_BIT = 8,
    parameter int DATA_BIT = 112,
    parameter int NUM_REQ  = 2,
    parameter int ID_BIT   = 1
);
    logic                         WR_VALID;
    logic                         WR_READY;
    logic [ADDR_BIT-1:0]          WR_ADDR;
    logic [DATA_BIT-1:0]          WR_DATA;
    logic [NUM_REQ-1:0]           REQ_VALID;
    logic [NUM_REQ-1:0]           REQ_READY;
    logic [NUM_REQ*ADDR_BIT-1:0]  REQ_ADDR;
    logic [NUM_REQ*ADDR_BIT-1:0]  REQ_LEN;
    logic                         RD_VALID;
    logic [DATA_BIT-1:0]          RD_DATA;
    logic [ID_BIT-1:0]            RD_ID;
    logic                         RD_LAST;
    logic                         BUSY;
    logic                         SRAM_EN_M;
    logic [ADDR_BIT-1:0]          SRAM_ADDR;
    logic                         SRAM_WE;
    logic [ADDR_BIT-1:0]          SRAM_ADDR_WRITE;
    logic [DATA_BIT-1:0]          SRAM_DIN;
    logic [DATA_BIT-1:0]          SRAM_DOUT;

    // Controller side.
    modport slave (
        input  WR_VALID, WR_ADDR, WR_DATA,
        input  REQ_VALID, REQ_ADDR, REQ_LEN,
        input  SRAM_DOUT,
        output WR_READY, REQ_READY,
        output RD_VALID, RD_DATA, RD_ID, RD_LAST, BUSY,
        output SRAM_EN_M, SRAM_ADDR, SRAM_WE, SRAM_ADDR_WRITE, SRAM_DIN
    );

    // Loader / requesters / SRAM side.
    modport master (
        output WR_VALID, WR_ADDR, WR_DATA,
        output REQ_VALID, REQ_ADDR, REQ_LEN,
        output SRAM_DOUT,
        input  WR_READY, REQ_READY,
        input  RD_VALID, RD_DATA, RD_ID, RD_LAST, BUSY,
        input  SRAM_EN_M, SRAM_ADDR, SRAM_WE, SRAM_ADDR_WRITE, SRAM_DIN
    );
endinterface

// File: rtl/sdfa_sram_ctrl.sv
// rtl/sdfa_sram_ctrl.sv - read/write sequencer for the 256 x 112-bit LSTM weight SRAM

module sdfa_sram_ctrl #(
    parameter int ADDR_BIT = 8,
    parameter int DATA_BIT = 112,
    parameter int NUM_REQ  = 2,
    parameter int ID_BIT   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    sdfa_sram_ctrl_if.slave  bus
);

    typedef enum logic {
        ST_IDLE,
        ST_READ
    } state_t;

    state_t                 state_q;
    logic [ID_BIT-1:0]      rr_q;
    logic [ID_BIT-1:0]      owner_q;
    logic [ADDR_BIT-1:0]    cnt_q;
    logic [ADDR_BIT-1:0]    rem_q;

    // Stage 1: word issued last cycle, SRAM_DOUT carries it now.
    logic                   p1_valid_q;
    logic                   p1_last_q;
    logic [ID_BIT-1:0]      p1_id_q;

    // Stage 2: registered read return.
    logic                   rd_valid_q;
    logic                   rd_last_q;
    logic [ID_BIT-1:0]      rd_id_q;
    logic [DATA_BIT-1:0]    rd_data_q;

    // Accepted write still travelling toward its commit edge inside the SRAM.
    logic                   wr_p1_q;
    logic                   wr_p2_q;

    logic                   any_req_c;
    logic [ID_BIT-1:0]      idx_c;
    logic [ID_BIT-1:0]      win_c;
    logic [ID_BIT-1:0]      rr_next_c;
    logic                   wr_ready_c;
    logic                   wr_fire_c;
    logic [NUM_REQ-1:0]     req_ready_c;
    logic                   req_fire_c;

    // Round-robin search: first requesting index at or after rr, wrapping.
    always_comb begin
        any_req_c = 1'b0;
        idx_c     = '0;
        win_c     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_c = ID_BIT'((int'(rr_q) + i) % NUM_REQ);
            if (!any_req_c && bus.REQ_VALID[idx_c]) begin
                any_req_c = 1'b1;
                win_c     = idx_c;
            end
        end
        rr_next_c = (int'(win_c) == NUM_REQ - 1) ? '0 : win_c + 1'b1;
    end

    // Handshakes: writes win over reads, and nothing is granted outside IDLE or in reset.
    always_comb begin
        wr_ready_c  = (state_q == ST_IDLE) && !RST;
        wr_fire_c   = wr_ready_c && bus.WR_VALID;
        req_ready_c = '0;
        if (wr_ready_c && !bus.WR_VALID && any_req_c) begin
            req_ready_c[win_c] = 1'b1;
        end
        req_fire_c  = |(req_ready_c & bus.REQ_VALID);
    end

    // Burst sequencing FSM plus read-return pipeline and write-commit tracking.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            p1_valid_q <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_id_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_id_q    <= '0;
            rd_data_q  <= '0;
            wr_p1_q    <= 1'b0;
            wr_p2_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_fire_c) begin
                        cnt_q   <= bus.REQ_ADDR[win_c*ADDR_BIT +: ADDR_BIT];
                        rem_q   <= bus.REQ_LEN[win_c*ADDR_BIT +: ADDR_BIT];
                        owner_q <= win_c;
                        rr_q    <= rr_next_c;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    cnt_q <= cnt_q + 1'b1;
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == '0) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            p1_valid_q <= (state_q == ST_READ);
            p1_last_q  <= (state_q == ST_READ) && (rem_q == '0);
            p1_id_q    <= owner_q;

            rd_valid_q <= p1_valid_q;
            rd_last_q  <= p1_last_q;
            rd_id_q    <= p1_id_q;
            if (p1_valid_q) begin
                rd_data_q <= bus.SRAM_DOUT;
            end

            wr_p1_q <= wr_fire_c;
            wr_p2_q <= wr_p1_q;
        end
    end

    assign bus.WR_READY        = wr_ready_c;
    assign bus.REQ_READY       = req_ready_c;
    assign bus.RD_VALID        = rd_valid_q;
    assign bus.RD_DATA         = rd_data_q;
    assign bus.RD_ID           = rd_id_q;
    assign bus.RD_LAST         = rd_last_q;
    assign bus.BUSY            = (state_q == ST_READ) || p1_valid_q || rd_valid_q || wr_p1_q || wr_p2_q;
    assign bus.SRAM_EN_M       = (state_q != ST_READ);
    assign bus.SRAM_ADDR       = cnt_q;
    assign bus.SRAM_WE         = !wr_fire_c;
    assign bus.SRAM_ADDR_WRITE = bus.WR_ADDR;
    assign bus.SRAM_DIN        = bus.WR_DATA;

endmodule

// File: tb/tb_sdfa_sram_ctrl.sv
// tb/tb_sdfa_sram_ctrl.sv - randomized self-checking bench for sdfa_sram_ctrl

module tb_sdfa_sram_ctrl;

    localparam int AB = 8;
    localparam int DB = 112;
    localparam int NR = 2;
    localparam int IB = 1;

    typedef struct {
        logic [DB-1:0] data;
        int            id;
        bit            last;
        int            cyc;
    } beat_t;

    typedef struct {
        int addr;
        int cyc;
    } ad_t;

    logic CLK = 1'b0;
    logic RST;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [DB-1:0] ref_mem [256];
    int            rr_model = 0;
    beat_t         exp_beats [$];
    ad_t           exp_addr [$];
    beat_t         mon_b;
    ad_t           mon_a;

    sdfa_sram_ctrl_if #(.ADDR_BIT(AB), .DATA_BIT(DB), .NUM_REQ(NR), .ID_BIT(IB)) bus ();

    sdfa_sram_ctrl #(.ADDR_BIT(AB), .DATA_BIT(DB), .NUM_REQ(NR), .ID_BIT(IB)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // SRAM: write lands two edges after acceptance; a read captured on that same edge sees it.
    logic [DB-1:0] sram_mem [256];
    logic          we_p1 = 1'b0;
    logic          we_p2 = 1'b0;
    logic [AB-1:0] wa_p1, wa_p2;
    logic [DB-1:0] d_p1, d_p2;

    always @(posedge CLK) begin
        if (!bus.SRAM_EN_M)
            bus.SRAM_DOUT <= (we_p2 && wa_p2 == bus.SRAM_ADDR) ? d_p2 : sram_mem[bus.SRAM_ADDR];
        if (we_p2)
            sram_mem[wa_p2] <= d_p2;
        we_p1 <= !bus.SRAM_WE;
        wa_p1 <= bus.SRAM_ADDR_WRITE;
        d_p1  <= bus.SRAM_DIN;
        we_p2 <= we_p1;
        wa_p2 <= wa_p1;
        d_p2  <= d_p1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int r);
        logic [NR-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    // Expected issue addresses and returned beats of a burst accepted at edge k.
    function automatic void push_expected(input int r, input int a, input int len, input int k);
        for (int i = 0; i <= len; i++) begin
            beat_t b;
            ad_t   x;
            b.data = ref_mem[(a + i) % 256];
            b.id   = r;
            b.last = (i == len);
            b.cyc  = k + 2 + i;
            exp_beats.push_back(b);
            x.addr = (a + i) % 256;
            x.cyc  = k + i;
            exp_addr.push_back(x);
        end
    endfunction

    // Monitor: every SRAM read issue and every returned beat must be expected, in order and on time.
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (!bus.SRAM_EN_M) begin
                if (exp_addr.size() == 0) begin
                    check("sram_en_spurious", 1, 0);
                end else begin
                    mon_a = exp_addr.pop_front();
                    check("sram_addr", bus.SRAM_ADDR, mon_a.addr);
                    check("sram_addr_cyc", cyc, mon_a.cyc);
                end
            end
            if (bus.RD_VALID) begin
                if (exp_beats.size() == 0) begin
                    check("rd_spurious", 1, 0);
                end else begin
                    mon_b = exp_beats.pop_front();
                    check("rd_data", bus.RD_DATA, mon_b.data);
                    check("rd_id", bus.RD_ID, mon_b.id);
                    check("rd_last", bus.RD_LAST, mon_b.last);
                    check("rd_cyc", cyc, mon_b.cyc);
                end
            end
        end
    end

    task automatic do_write(input int a, input logic [DB-1:0] d);
        @(posedge CLK); #1;
        bus.WR_VALID = 1'b1;
        bus.WR_ADDR  = AB'(a);
        bus.WR_DATA  = d;
        @(negedge CLK);
        check("wr_ready", bus.WR_READY, 1);
        check("sram_we", bus.SRAM_WE, 0);
        check("sram_addr_write", bus.SRAM_ADDR_WRITE, a);
        check("sram_din", bus.SRAM_DIN, d);
        @(posedge CLK); #1;
        bus.WR_VALID = 1'b0;
        ref_mem[a]   = d;
        @(negedge CLK);
        check("busy_wr0", bus.BUSY, 1);
        @(negedge CLK);
        check("busy_wr1", bus.BUSY, 1);
        @(negedge CLK);
        check("busy_wr_done", bus.BUSY, 0);
    endtask

    task automatic issue_burst(input int r, input int a, input int len, output int k);
        bit got;
        @(posedge CLK); #1;
        bus.REQ_VALID              = onehot(r);
        bus.REQ_ADDR[r*AB +: AB]   = AB'(a);
        bus.REQ_LEN[r*AB +: AB]    = AB'(len);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge CLK);
            if (bus.REQ_READY != '0) got = 1'b1;
        end
        check("grant_timeout", got, 1);
        check("req_grant", bus.REQ_READY, onehot(r));
        @(posedge CLK); #1;
        k             = cyc;
        bus.REQ_VALID = '0;
        push_expected(r, a, len, k);
        rr_model = (r + 1) % NR;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_beats.size() != 0 || exp_addr.size() != 0) && t < 600) begin
            @(posedge CLK);
            t++;
        end
        check("drain_left", exp_beats.size() + exp_addr.size(), 0);
        exp_beats.delete();
        exp_addr.delete();
        @(negedge CLK);
        check("busy_idle", bus.BUSY, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int prev_k;
        int exp_r;
        bit got;
        logic [DB-1:0] d;

        RST           = 1'b1;
        bus.WR_VALID  = 1'b1;
        bus.WR_ADDR   = '0;
        bus.WR_DATA   = '0;
        bus.REQ_VALID = 2'b11;
        bus.REQ_ADDR  = '0;
        bus.REQ_LEN   = '0;

        // Reset holds every handshake closed even with requests pending.
        repeat (3) begin
            @(negedge CLK);
            check("rst_wr_ready", bus.WR_READY, 0);
            check("rst_req_ready", bus.REQ_READY, 0);
            check("rst_en_m", bus.SRAM_EN_M, 1);
            check("rst_we", bus.SRAM_WE, 1);
            check("rst_rd_valid", bus.RD_VALID, 0);
            check("rst_busy", bus.BUSY, 0);
        end
        check("rst_rd_data", bus.RD_DATA, 0);
        check("rst_rd_id", bus.RD_ID, 0);
        check("rst_rd_last", bus.RD_LAST, 0);
        @(posedge CLK); #1;
        bus.WR_VALID  = 1'b0;
        bus.REQ_VALID = '0;
        RST           = 1'b0;

        // Write then burst read back.
        for (int i = 0; i < 4; i++) do_write(8'h10 + i, DB'(8'hA0 + i));
        issue_burst(0, 8'h10, 3, k);
        drain();

        // Address wrap 0xFF -> 0x00 inside a burst.
        for (int i = 0; i < 4; i++) begin
            d = DB'({$urandom, $urandom, $urandom, $urandom});
            do_write((8'hFE + i) % 256, d);
        end
        issue_burst(1, 8'hFE, 3, k);
        drain();

        // Round robin with both requesters permanently asking.
        do_write(8'h30, DB'(16'h1111));
        do_write(8'h31, DB'(16'h2222));
        @(posedge CLK); #1;
        bus.REQ_VALID         = 2'b11;
        bus.REQ_ADDR[0 +: AB] = 8'h30;
        bus.REQ_ADDR[AB +: AB] = 8'h31;
        bus.REQ_LEN           = '0;
        prev_k = 0;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge CLK);
                if (bus.REQ_READY != '0) got = 1'b1;
            end
            check("rr_timeout", got, 1);
            exp_r = rr_model;
            check("rr_grant", bus.REQ_READY, onehot(exp_r));
            @(posedge CLK); #1;
            k = cyc;
            if (g == 3) bus.REQ_VALID = '0;
            push_expected(exp_r, (exp_r == 0) ? 8'h30 : 8'h31, 0, k);
            rr_model = (exp_r + 1) % NR;
            if (g > 0) check("rr_gap", k - prev_k, 2);
            prev_k = k;
        end
        drain();

        // Write priority, then a read of the same word on the very next grant.
        do_write(8'h20, DB'(8'h33));
        @(posedge CLK); #1;
        bus.WR_VALID          = 1'b1;
        bus.WR_ADDR           = 8'h20;
        bus.WR_DATA           = DB'(8'h55);
        bus.REQ_VALID         = 2'b01;
        bus.REQ_ADDR[0 +: AB] = 8'h20;
        bus.REQ_LEN[0 +: AB]  = 8'h00;
        @(negedge CLK);
        check("prio_wr_ready", bus.WR_READY, 1);
        check("prio_req_ready", bus.REQ_READY, 0);
        @(posedge CLK); #1;
        bus.WR_VALID  = 1'b0;
        ref_mem[8'h20] = DB'(8'h55);
        @(negedge CLK);
        check("prio_grant", bus.REQ_READY, 2'b01);
        @(posedge CLK); #1;
        k             = cyc;
        bus.REQ_VALID = '0;
        push_expected(0, 8'h20, 0, k);
        rr_model = 1;
        drain();

        // Reset in the third READ cycle of an 8-word burst.
        for (int i = 0; i < 8; i++) begin
            d = DB'({$urandom, $urandom, $urandom, $urandom});
            do_write(8'h40 + i, d);
        end
        issue_burst(0, 8'h40, 7, k);
        @(posedge CLK);
        @(posedge CLK); #1;
        RST = 1'b1;
        exp_beats.delete();
        exp_addr.delete();
        #1;
        check("mid_rst_rd_valid", bus.RD_VALID, 0);
        check("mid_rst_en_m", bus.SRAM_EN_M, 1);
        check("mid_rst_busy", bus.BUSY, 0);
        check("mid_rst_wr_ready", bus.WR_READY, 0);
        @(posedge CLK); #1;
        RST      = 1'b0;
        rr_model = 0;
        @(negedge CLK);
        check("post_rst_idle", bus.WR_READY, 1);
        check("post_rst_rd_valid", bus.RD_VALID, 0);
        issue_burst(1, 8'h42, 3, k);
        drain();

        // Random writes followed by random bursts.
        for (int it = 0; it < 8; it++) begin
            int nw;
            int ra;
            int rl;
            int rq;
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                d = DB'({$urandom, $urandom, $urandom, $urandom});
                do_write($urandom_range(0, 255), d);
            end
            ra = $urandom_range(0, 255);
            rl = $urandom_range(0, 12);
            rq = $urandom_range(0, NR - 1);
            issue_burst(rq, ra, rl, k);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
